// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the seven-segment scan controller: data/strobe/blanking in,
// decoder nibble, anodes and status pulses out.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;
    logic                upd_ack;

    modport master (
        output data, load, blank_mask,
        input  nib, an, frame_tick, upd_ack
    );

    modport slave (
        input  data, load, blank_mask,
        output nib, an, frame_tick, upd_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with all-off guard gaps and double-buffered data.
// Define SEG_SCAN_LZ_BLANK_EN to also blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic {ST_GAP = 1'b0, ST_SHOW = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic [4*DIGITS-1:0] r_pend, w_pend_next;
    logic                r_pend_valid, w_pend_valid_next;
    logic [4*DIGITS-1:0] r_act;
    logic [DIGITS-1:0]   r_an, w_an_next;
    logic [3:0]          r_nib, w_nib_next;
    logic                r_frame_tick, w_frame_tick_next;
    logic                r_upd_ack, w_upd_ack_next;

    logic                w_gap_done;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_frame_start;
    logic                w_commit;
    logic [4*DIGITS-1:0] w_act_next;
    logic [DIGITS-1:0]   w_lz_mask;
    logic                w_blank;

    // Commit happens only on the GAP->SHOW edge into digit 0, so a frame never mixes buffers.
    assign w_gap_done    = (r_state == ST_GAP) && (r_cnt == GAP_LAST);
    assign w_idx_inc     = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_frame_start = w_gap_done && (w_idx_inc == '0);
    assign w_commit      = w_frame_start && r_pend_valid;
    assign w_act_next    = w_commit ? r_pend : r_act;

`ifdef SEG_SCAN_LZ_BLANK_EN
    genvar gi;
    assign w_lz_mask[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign w_lz_mask[gi] = (w_act_next[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate
`else
    assign w_lz_mask = '0;
`endif

    assign w_blank = bus.blank_mask[w_idx_inc] | w_lz_mask[w_idx_inc];

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt + 1'b1;
        w_idx_next        = r_idx;
        w_pend_next       = r_pend;
        w_pend_valid_next = r_pend_valid;
        w_an_next         = r_an;
        w_nib_next        = r_nib;
        w_frame_tick_next = 1'b0;
        w_upd_ack_next    = 1'b0;
        case (r_state)
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_next      = ST_SHOW;
                    w_cnt_next        = '0;
                    w_idx_next        = w_idx_inc;
                    w_frame_tick_next = w_frame_start;
                    w_upd_ack_next    = w_commit;
                    w_nib_next        = w_act_next[4*int'(w_idx_inc) +: 4];
                    if (!w_blank) w_an_next[w_idx_inc] = 1'b0;
                    if (w_commit) w_pend_valid_next = 1'b0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = '0;
                    w_an_next    = '1;
                    w_nib_next   = '0;
                end
            end
            default: w_state_next = ST_GAP;
        endcase
        // A load in the commit cycle lands after the commit, so it survives for the next frame.
        if (bus.load) begin
            w_pend_next       = bus.data;
            w_pend_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_GAP;
            r_cnt        <= '0;
            r_idx        <= IDX_LAST;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_act        <= '0;
            r_an         <= '1;
            r_nib        <= '0;
            r_frame_tick <= 1'b0;
            r_upd_ack    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_pend       <= w_pend_next;
            r_pend_valid <= w_pend_valid_next;
            r_act        <= w_act_next;
            r_an         <= w_an_next;
            r_nib        <= w_nib_next;
            r_frame_tick <= w_frame_tick_next;
            r_upd_ack    <= w_upd_ack_next;
        end
    end

    assign bus.nib        = r_nib;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_frame_tick;
    assign bus.upd_ack    = r_upd_ack;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-position reference model checked every cycle, a table of
// display vectors, hand-written corner sequences and a randomized soak.
module tb_seg_scan_ctrl;
    localparam int D     = 4;
    localparam int P     = 4;
    localparam int G     = 2;
    localparam int SLOT  = P + G;
    localparam int FRAME = D * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(D)) bus ();

    seg_scan_ctrl #(
        .DIGITS    (D),
        .PRESCALE  (P),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position in the frame follows from the edge count k since reset.
    int          k      = 0;
    logic [15:0] m_act  = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv   = 1'b0;
    bit          m_blank = 1'b0;
    bit          m_ack  = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  bm;
        logic [3:0]  lit;
    } vec_t;
    vec_t tbl[7];

    function automatic bit lz(input logic [15:0] a, input int s);
`ifdef SEG_SCAN_LZ_BLANK_EN
        return (s >= 1) && ((a >> (4*s)) == 16'h0);
`else
        return (s < 0) && (a == 16'h0);
`endif
    endfunction

    task automatic check(input string name, input bit ok, input string got, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, got, exp);
        end
    endtask

    task automatic step();
        logic        l, r;
        logic [15:0] d;
        logic [3:0]  bm;
        logic [3:0]  e_an;
        logic [3:0]  e_nib;
        int          p, s, o;
        bit          lit, chk_nib, ok;
        l  = bus.load;
        d  = bus.data;
        bm = bus.blank_mask;
        r  = rst;
        @(posedge clk);
        m_ack = 1'b0;
        if (r) begin
            k = 0; m_act = '0; m_pend = '0; m_pv = 1'b0; m_blank = 1'b0;
        end else begin
            k++;
            p = k % FRAME; s = p / SLOT; o = p % SLOT;
            if (p == G && m_pv) begin
                m_act = m_pend; m_pv = 1'b0; m_ack = 1'b1;
            end
            if (o == G) m_blank = bm[s] | lz(m_act, s);
            if (l) begin
                m_pend = d; m_pv = 1'b1;
            end
        end
        #1;
        p = k % FRAME; s = p / SLOT; o = p % SLOT;
        lit     = (o >= G);
        e_an    = (lit && !m_blank) ? ~(4'b0001 << s) : 4'b1111;
        chk_nib = lit || (k == 0);
        e_nib   = (k == 0) ? 4'h0 : m_act[4*s +: 4];
        ok = (bus.an == e_an) && (bus.frame_tick == (p == G)) && (bus.upd_ack == m_ack)
             && (!chk_nib || bus.nib == e_nib);
        check($sformatf("cycle k=%0d", k), ok,
              $sformatf("an=%b ft=%b ack=%b nib=%h", bus.an, bus.frame_tick, bus.upd_ack, bus.nib),
              $sformatf("an=%b ft=%b ack=%b nib=%h(chk=%0d)", e_an, (p == G), m_ack, e_nib, chk_nib));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_phase(input int target);
        for (int i = 0; i <= FRAME && (k % FRAME) != target; i++) step();
    endtask

    task automatic load_data(input logic [15:0] v);
        bus.data = v;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        $display("load data=%h at k=%0d", v, k);
    endtask

    // Watches one whole frame starting at its frame_tick; records which digits lit and what nib showed.
    task automatic observe_frame(output logic [15:0] nibs, output logic [3:0] lit, output int acks);
        nibs = '0; lit = '0; acks = 0;
        to_phase(G - 1);
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int i = 0; i < D; i++) begin
                if (bus.an[i] == 1'b0) begin
                    lit[i] = 1'b1;
                    nibs[4*i +: 4] = bus.nib;
                end
            end
            if (bus.upd_ack) acks++;
        end
    endtask

    function automatic logic [15:0] lit_mask(input logic [3:0] lit);
        logic [15:0] m;
        for (int i = 0; i < 4; i++) m[4*i +: 4] = {4{lit[i]}};
        return m;
    endfunction

    logic [15:0] nibs;
    logic [3:0]  lit, exp_lit;
    int          acks;

    initial begin
        tbl[0] = '{16'h12AF, 4'b0000, 4'b1111};
        tbl[1] = '{16'h2222, 4'b0000, 4'b1111};
        tbl[3] = '{16'h5A5A, 4'b1010, 4'b0101};
        tbl[5] = '{16'h9876, 4'b1111, 4'b0000};
`ifdef SEG_SCAN_LZ_BLANK_EN
        tbl[2] = '{16'h0030, 4'b0000, 4'b0011};
        tbl[4] = '{16'h0000, 4'b0000, 4'b0001};
        tbl[6] = '{16'h0700, 4'b0001, 4'b0110};
`else
        tbl[2] = '{16'h0030, 4'b0000, 4'b1111};
        tbl[4] = '{16'h0000, 4'b0000, 4'b1111};
        tbl[6] = '{16'h0700, 4'b0001, 4'b1110};
`endif
        bus.data = '0;
        bus.load = 1'b0;
        bus.blank_mask = '0;

        // Reset state, then two idle frames with nib=0 and the plain scan pattern.
        rst = 1'b1;
        run(3);
        check("reset outputs", {bus.an, bus.nib, bus.frame_tick, bus.upd_ack} == {4'hF, 4'h0, 1'b0, 1'b0},
              $sformatf("an=%b nib=%h ft=%b ack=%b", bus.an, bus.nib, bus.frame_tick, bus.upd_ack),
              "an=1111 nib=0 ft=0 ack=0");
        rst = 1'b0;
        run(2 * FRAME);

        for (int t = 0; t < 7; t++) begin
            to_phase(G + 3);
            bus.blank_mask = tbl[t].bm;
            load_data(tbl[t].data);
            observe_frame(nibs, lit, acks);
            $display("vector %0d data=%h bm=%b lit=%b nibs=%h acks=%0d", t, tbl[t].data, tbl[t].bm, lit, nibs, acks);
            check($sformatf("vec%0d lit", t), lit == tbl[t].lit, $sformatf("%b", lit), $sformatf("%b", tbl[t].lit));
            check($sformatf("vec%0d nibs", t), (nibs & lit_mask(tbl[t].lit)) == (tbl[t].data & lit_mask(tbl[t].lit)),
                  $sformatf("%h", nibs), $sformatf("%h", tbl[t].data));
            check($sformatf("vec%0d acks", t), acks == 1, $sformatf("%0d", acks), "1");
        end
        bus.blank_mask = '0;

        // Two loads in one frame: only the latest is shown, committed once.
        to_phase(G + 1);
        load_data(16'h1111);
        run(3);
        load_data(16'h2222);
        observe_frame(nibs, lit, acks);
        check("double load acks", acks == 1, $sformatf("%0d", acks), "1");
        check("double load nibs", nibs == 16'h2222 && lit == 4'hF, $sformatf("%h/%b", nibs, lit), "2222/1111");

        // Load landing on the commit edge: old pend committed now, new one next frame.
        to_phase(G + 1);
        load_data(16'h0005);
        to_phase(G - 1);
        load_data(16'h0009);
        check("commit edge", {bus.upd_ack, bus.frame_tick, bus.an, bus.nib} == {1'b1, 1'b1, 4'b1110, 4'h5},
              $sformatf("ack=%b ft=%b an=%b nib=%h", bus.upd_ack, bus.frame_tick, bus.an, bus.nib),
              "ack=1 ft=1 an=1110 nib=5");
        observe_frame(nibs, lit, acks);
`ifdef SEG_SCAN_LZ_BLANK_EN
        exp_lit = 4'b0001;
`else
        exp_lit = 4'b1111;
`endif
        check("second commit acks", acks == 1, $sformatf("%0d", acks), "1");
        check("second commit nibs", lit == exp_lit && (nibs & lit_mask(exp_lit)) == (16'h0009 & lit_mask(exp_lit)),
              $sformatf("%h/%b", nibs, lit), $sformatf("0009/%b", exp_lit));

        // Reset during SHOW of digit 2 with pending data: pending data discarded.
        to_phase(G + 1);
        load_data(16'h4321);
        to_phase(2 * SLOT + G + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid reset outputs", bus.an == 4'hF && bus.nib == 4'h0,
              $sformatf("an=%b nib=%h", bus.an, bus.nib), "an=1111 nib=0");
        observe_frame(nibs, lit, acks);
        check("post reset acks", acks == 0, $sformatf("%0d", acks), "0");
        check("post reset nibs", lit == exp_lit && nibs == 16'h0000,
              $sformatf("%h/%b", nibs, lit), $sformatf("0000/%b", exp_lit));

        // Randomized soak against the model.
        for (int c = 0; c < 1500; c++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            bus.data = 16'($urandom);
            if ($urandom_range(0, 63) == 0) bus.blank_mask = 4'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            if (bus.load) $display("random load data=%h at k=%0d", bus.data, k + 1);
            step();
        end
        bus.load = 1'b0;
        rst = 1'b0;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display. Sequences one shared nibble-to-segment decoder across DIGITS common-anode digits: it presents one digit's nibble at a time on `nib` (wired to the decoder input) and drives the matching active-low anode. It inserts an all-off guard gap between digits to prevent ghosting, and double-buffers display data so frames never tear.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- PRESCALE, 1000, clock cycles each digit is lit (≥1)
- GAP_CYCLES, 2, clock cycles all anodes are off between digits (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- data  in  4*DIGITS  display value; digit i = data[4i+3:4i], digit 0 rightmost
- load  in  1  one-cycle strobe; captures `data` into the pending buffer
- blank_mask  in  DIGITS  1 = force digit i dark; sampled live at each GAP→SHOW transition
- nib  out  4  nibble of the current digit, to decoder input
- an  out  DIGITS  anode enables, active-low, at most one low at a time
- frame_tick  out  1  one-cycle pulse on entry to SHOW of digit 0
- upd_ack  out  1  one-cycle pulse when pending data is committed to the active buffer

## Operation
- Registers: `pend` (4*DIGITS), `pend_valid`, `act` (4*DIGITS), `idx` (digit index), `cnt` (phase counter), `state` ∈ {GAP, SHOW}.
- Reset values: state=GAP, cnt=0, idx=DIGITS-1, act=0, pend=0, pend_valid=0, an=all 1, nib=0, frame_tick=0, upd_ack=0.
- `load`=1: pend←data, pend_valid←1. This applies in every state. A later load overwrites pend; the latest value wins.
- GAP: an=all 1. cnt counts 0..GAP_CYCLES-1. At cnt=GAP_CYCLES-1:
  - idx←(idx+1) mod DIGITS, cnt←0, state←SHOW.
- GAP→SHOW into idx 0:
  - If pend_valid: act←pend, pend_valid←0, upd_ack=1 that cycle. nib and blanking use the newly committed value.
  - frame_tick=1.
- SHOW: nib=act digit idx. an[idx]=0 unless the digit is blanked, in which case an stays all 1 and nib is still driven. cnt counts 0..PRESCALE-1. At cnt=PRESCALE-1: cnt←0, state←GAP.
- Blanked digit: blank_mask[idx]=1 (plus the macro rule below). The slot keeps full duration, so frame timing is independent of blanking.
- Simultaneous load and commit in the same cycle: the commit uses the old pend. The new data lands in pend and pend_valid stays 1 for the next frame.
- idx wraps DIGITS-1→0. No other sequence is legal.
- rst mid-frame returns all registers to reset values on the next edge. Pending data is discarded.

## Timing
- All outputs are registered and change on the same edge as the state transition.
- An anode is low for exactly PRESCALE consecutive cycles. It is followed by exactly GAP_CYCLES all-high cycles.
- Frame period = DIGITS*(PRESCALE+GAP_CYCLES) cycles. frame_tick is periodic at that rate.
- First lit cycle after reset release: cycle GAP_CYCLES after the first post-reset edge (digit 0).
- Load-to-display latency: up to one frame plus GAP_CYCLES. Data is visible from the next frame_tick after the load.
- upd_ack coincides with frame_tick. It is never asserted without frame_tick.

## Configuration
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: digit i (i≥1) is additionally blanked when act digits i..DIGITS-1 are all 0. Digit 0 is never blanked by this rule. Evaluated at each GAP→SHOW against `act` after any commit.
- Undefined: only blank_mask blanks digits. Leading zeros are displayed. No zero-detect logic is compiled.

## Test plan
Parameters for all scenarios: DIGITS=4, PRESCALE=4, GAP_CYCLES=2.
- Reset release, no load → an pattern repeats with a 24-cycle period: 2 cycles 1111, 4 cycles 1110, 2 cycles 1111, 4 cycles 1101, and so on. nib=0 throughout SHOW. frame_tick every 24 cycles.
- load with data=16'h12AF mid-frame → no change to nib until the next frame_tick. Then upd_ack=1 with frame_tick, and nib sequence F, A, 2, 1 on an[0..3].
- Two loads in one frame (16'h1111 then 16'h2222) → one upd_ack only, and the display shows 2222.
- load coinciding with the commit cycle (pend=16'h0005, new data 16'h0009) → displays 0005 this frame, then 0009 after the next frame_tick with a second upd_ack.
- blank_mask=4'b1010 → an[1] and an[3] never go low, with slot timing unchanged. With SEG_SCAN_LZ_BLANK_EN and data=16'h0030, an[3] stays high, an[2] stays high, an[1] shows 3, and an[0] shows 0.
- rst asserted during SHOW of digit 2 with pend_valid=1 → next cycle an=1111, nib=0. After release, digit 0 is lit with nib=0 and upd_ack never fires.
